// File: rtl/debounce_pkg.sv
// Shared defaults and an elaboration-time sanity check for the debounce bank.
// Lets STABLE_CYCLES/CNT_W pairings be validated before any logic is built.
package debounce_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 50000;
  localparam int DEFAULT_CNT_W         = 16;
  localparam int DEFAULT_ACTIVE_LOW    = 1;

  // True when a CNT_W-bit counter can reach STABLE_CYCLES-1 without wrapping.
  function automatic bit cnt_w_ok(int cnt_w, int stable_cycles);
    return (stable_cycles >= 1) && ($clog2(stable_cycles) <= cnt_w);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop sync, stability counter, level and edge pulses.
// Latency: STABLE_CYCLES+1 edges from first s1 capture; no backpressure (free-running).
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CNT_W         = DEFAULT_CNT_W,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = DEFAULT_ACTIVE_LOW
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic ledg,
  output logic press,
  output logic rel
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             b;
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  assign b = (ACTIVE_LOW != 0) ? ~button : button;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      ledg  <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= b;
      s2    <= s1;
      press <= 1'b0;
      rel   <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the full count.
      if (s2 == ledg) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        ledg  <= s2;
        press <= s2;
        rel   <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounce channels; outputs are 1 = pressed regardless of board polarity.
// Latency: STABLE_CYCLES+1 edges after first capture; no backpressure.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CNT_W         = DEFAULT_CNT_W,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = DEFAULT_ACTIVE_LOW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] ledg,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel    // release pulse; "release" is a reserved word
);

  if (!cnt_w_ok(CNT_W, STABLE_CYCLES)) begin : g_bad_cfg
    $error("debounce_bank: CNT_W=%0d cannot count STABLE_CYCLES=%0d", CNT_W, STABLE_CYCLES);
  end

  for (genvar n = 0; n < N_CH; n++) begin : g_ch
    debounce_ch #(
      .CNT_W        (CNT_W),
      .STABLE_CYCLES(STABLE_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .button(button[n]),
      .ledg  (ledg[n]),
      .press (press[n]),
      .rel   (rel[n])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench: active-low bank with STABLE_CYCLES=4, plus an active-high STABLE_CYCLES=1 bank.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] button;
  logic [3:0] ledg, press, rel;
  logic [3:0] button2;
  logic [3:0] ledg2, press2, rel2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debounce_bank #(.N_CH(4), .CNT_W(3), .STABLE_CYCLES(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .button(button),
    .ledg(ledg), .press(press), .rel(rel)
  );

  debounce_bank #(.N_CH(4), .CNT_W(1), .STABLE_CYCLES(1), .ACTIVE_LOW(0)) dut2 (
    .clk(clk), .reset(reset), .button(button2),
    .ledg(ledg2), .press(press2), .rel(rel2)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    button  = 4'b1111;
    button2 = 4'b0000;
    tick(2);
    reset = 1'b0;
    chk("rst_ledg", ledg, 4'b0000);
    chk("rst_press", press, 4'b0000);
    chk("rst_rel", rel, 4'b0000);
    chk("rst_ledg2", ledg2, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("idle_ledg", ledg, 4'b0000);
      chk("idle_pulses", press | rel, 4'b0000);
    end

    // Channel 0 clean press
    button = 4'b1110;
    tick(1);
    tick(4);
    chk("ch0_early_ledg", ledg, 4'b0000);
    chk("ch0_early_press", press, 4'b0000);
    tick(1);
    chk("ch0_ledg", ledg, 4'b0001);
    chk("ch0_press", press, 4'b0001);
    chk("ch0_rel", rel, 4'b0000);
    tick(1);
    chk("ch0_press_end", press, 4'b0000);
    chk("ch0_ledg_hold", ledg, 4'b0001);

    // Channel 1 bounce: low, low, high, then low held
    button = 4'b1100;
    tick(2);
    button = 4'b1110;
    tick(1);
    button = 4'b1100;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("ch1_bounce_ledg", ledg, 4'b0001);
      chk("ch1_bounce_press", press, 4'b0000);
    end
    tick(1);
    chk("ch1_ledg", ledg, 4'b0011);
    chk("ch1_press", press, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("ch1_single_pulse", press, 4'b0000);
      chk("ch1_ledg_hold", ledg, 4'b0011);
    end

    // Channels 2 and 3 together
    button = 4'b0000;
    tick(5);
    chk("ch23_early", ledg, 4'b0011);
    tick(1);
    chk("ch23_ledg", ledg, 4'b1111);
    chk("ch23_press", press, 4'b1100);
    tick(1);
    chk("ch23_press_end", press, 4'b0000);
    button = 4'b1100;
    tick(5);
    chk("ch23_rel_early", rel, 4'b0000);
    tick(1);
    chk("ch23_rel_ledg", ledg, 4'b0011);
    chk("ch23_rel", rel, 4'b1100);
    chk("ch23_rel_nopress", press, 4'b0000);
    tick(1);
    chk("ch23_rel_end", rel, 4'b0000);

    // Release channels 0 and 1
    button = 4'b1111;
    tick(6);
    chk("ch01_rel", rel, 4'b0011);
    chk("ch01_rel_ledg", ledg, 4'b0000);
    tick(4);

    // Reset mid-count, button kept low through it
    button = 4'b1110;
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("midcnt_rst_ledg", ledg, 4'b0000);
    chk("midcnt_rst_pulses", press | rel, 4'b0000);
    tick(1);
    reset = 1'b0;
    tick(5);
    chk("post_rst_early", press, 4'b0000);
    tick(1);
    chk("post_rst_press", press, 4'b0001);
    chk("post_rst_ledg", ledg, 4'b0001);
    // Reset while the pulse is high
    reset = 1'b1;
    tick(1);
    chk("midpulse_rst_press", press, 4'b0000);
    chk("midpulse_rst_ledg", ledg, 4'b0000);
    reset = 1'b0;

    // Active-high, STABLE_CYCLES=1
    button2 = 4'b0001;
    tick(2);
    chk("ah_early", ledg2, 4'b0000);
    tick(1);
    chk("ah_ledg", ledg2, 4'b0001);
    chk("ah_press", press2, 4'b0001);
    tick(1);
    chk("ah_press_end", press2, 4'b0000);
    button2 = 4'b0000;
    tick(3);
    chk("ah_rel", rel2, 4'b0001);
    chk("ah_rel_ledg", ledg2, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
